// File: rtl/booth_seq_mult_ctrl.sv
// booth_seq_mult_ctrl: iterative radix-4 Booth multiplier, one Booth digit retired per clock
module booth_seq_mult_ctrl #(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 busy
);
  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int JW     = $clog2(DIGITS);
  localparam int AW     = 2 * WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [JW-1:0]     j;
  logic [WIDTH-1:0]  a, b;
  logic [AW-1:0]     acc, acc_nx, mag, pp;
  logic [WIDTH+2:0]  b_ext;
  logic [2:0]        d;
  logic              accept, fin;

  always_comb begin
    b_ext     = {2'b00, b, 1'b0};
    d         = b_ext[{j, 1'b0} +: 3];
    mag       = (d == 3'b011 || d == 3'b100) ? {{(AW-WIDTH-1){1'b0}}, a, 1'b0} : {{(AW-WIDTH){1'b0}}, a};
    pp        = (d == 3'b000 || d == 3'b111) ? '0 : d[2] ? -mag : mag;
    acc_nx    = acc + (pp << {j, 1'b0});
    // early exit once every multiplier bit feeding a later digit is zero
    fin       = (j == JW'(DIGITS-1)) || (EARLY_TERM != 0 && (b >> {j, 1'b1}) == '0);
    in_ready  = !clear && (state == IDLE || (state == DONE && out_ready));
    accept    = in_valid && in_ready;
    busy      = state == RUN;
    out_valid = state == DONE;
    state_nx  = clear ? IDLE :
                accept ? RUN :
                state == RUN ? (fin ? DONE : RUN) :
                (state == DONE && !out_ready) ? DONE : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      j        <= '0;
      acc      <= '0;
      a        <= '0;
      b        <= '0;
      out_prod <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a   <= in_a;
        b   <= in_b;
        acc <= '0;
        j   <= '0;
      end else if (state == RUN && !clear) begin
        acc <= acc_nx;
        j   <= fin ? j : j + 1'b1;
        if (fin) out_prod <= acc_nx[2*WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// tb_booth_seq_mult_ctrl: directed and randomized checks of the Booth multiplier against a*b
module tb_booth_seq_mult_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        clear = 0;
  logic        vld  [2];
  logic        rdy  [2];
  logic [31:0] a_in [2];
  logic [31:0] b_in [2];
  logic        ovld [2];
  logic        ordy [2];
  logic [63:0] prod [2];
  logic        bsy  [2];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_seq_mult_ctrl #(.WIDTH(32), .EARLY_TERM(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_a(a_in[0]), .in_b(b_in[0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
    .out_prod(prod[0]), .busy(bsy[0]));

  booth_seq_mult_ctrl #(.WIDTH(32), .EARLY_TERM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_a(a_in[1]), .in_b(b_in[1]), .out_valid(ovld[1]), .out_ready(ordy[1]),
    .out_prod(prod[1]), .busy(bsy[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx, yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  function automatic logic [31:0] rnd_op();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? 32'd0 : r == 1 ? 32'hFFFF_FFFF : r == 2 ? ($urandom >> $urandom_range(0, 31)) : $urandom;
  endfunction

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!ovld[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] y, input int exp_lat);
    int lat;
    vld[k] = 1; a_in[k] = x; b_in[k] = y;
    #1 chk("accept_ready", 64'(rdy[k]), 1);
    @(negedge clk);
    vld[k] = 0;
    #1 chk("run_busy", 64'(bsy[k]), 1);
    wait_done(k, lat);
    chk("op_latency", 64'(lat), 64'(exp_lat));
    chk("op_prod", prod[k], model(x, y));
  endtask

  task automatic take(input int k);
    ordy[k] = 1;
    @(negedge clk);
    ordy[k] = 0;
    #1 chk("taken", 64'(ovld[k]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, seen;
    logic [63:0] held;
    logic [63:0] expv [2];
    logic        has  [2];
    logic        fired[2];
    int          acc_n[2], del_n[2];
    for (int k = 0; k < 2; k++) begin
      vld[k] = 0; ordy[k] = 0; a_in[k] = 0; b_in[k] = 0;
      has[k] = 0; fired[k] = 0; acc_n[k] = 0; del_n[k] = 0; expv[k] = 0;
    end
    repeat (3) @(negedge clk);
    #1 chk("rst_valid", 64'(ovld[0]), 0);
    chk("rst_prod", prod[0], 0);
    chk("rst_busy", 64'(bsy[0]), 0);
    chk("rst_ready", 64'(rdy[0]), 1);
    rst_n = 1;
    @(negedge clk);

    run_op(0, 32'd3, 32'd5, 17);
    chk("t1_prod", prod[0], 64'h0F);
    take(0);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17);
    chk("t2_prod", prod[0], 64'hFFFF_FFFE_0000_0001);
    take(0);

    run_op(0, 32'hDEAD_BEEF, 32'h1234_5678, 17);
    held = prod[0];
    repeat (5) begin
      @(negedge clk);
      #1 chk("hold_valid", 64'(ovld[0]), 1);
      chk("hold_prod", prod[0], held);
      chk("hold_ready", 64'(rdy[0]), 0);
    end
    ordy[0] = 1; vld[0] = 1; a_in[0] = 32'd2; b_in[0] = 32'h8000_0000;
    #1 chk("b2b_ready", 64'(rdy[0]), 1);
    @(negedge clk);
    vld[0] = 0; ordy[0] = 0;
    #1 chk("b2b_valid", 64'(ovld[0]), 0);
    chk("b2b_busy", 64'(bsy[0]), 1);
    wait_done(0, lat);
    chk("b2b_latency", 64'(lat), 17);
    chk("b2b_prod", prod[0], 64'h1_0000_0000);
    take(0);

    run_op(1, 32'd7, 32'd1, 1);
    take(1);
    run_op(1, 32'd5, 32'd7, 2);
    chk("et_35", prod[1], 64'd35);
    take(1);
    run_op(1, 32'h1234, 32'd0, 1);
    take(1);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17);
    take(1);

    vld[0] = 1; a_in[0] = 32'h1234; b_in[0] = 32'h5678;
    @(negedge clk);
    vld[0] = 0;
    repeat (7) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    #1 chk("clr_busy", 64'(bsy[0]), 0);
    chk("clr_valid", 64'(ovld[0]), 0);
    chk("clr_ready", 64'(rdy[0]), 1);
    chk("clr_prod_kept", prod[0], 64'h1_0000_0000);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ovld[0]) seen++;
    end
    chk("clr_no_output", 64'(seen), 0);

    vld[0] = 1; a_in[0] = 32'h1234; b_in[0] = 32'h5678;
    @(negedge clk);
    vld[0] = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    #1 chk("mrst_valid", 64'(ovld[0]), 0);
    chk("mrst_prod", prod[0], 0);
    chk("mrst_busy", 64'(bsy[0]), 0);
    chk("mrst_ready", 64'(rdy[0]), 1);
    rst_n = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ovld[0]) seen++;
    end
    chk("mrst_no_output", 64'(seen), 0);

    for (int c = 0; c < 30200; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (fired[k]) vld[k] = 0;
        fired[k] = 0;
        if (!vld[k] && c < 30000 && $urandom_range(0, 2) != 0) begin
          vld[k] = 1; a_in[k] = rnd_op(); b_in[k] = rnd_op();
        end
        ordy[k] = (c >= 30000) || ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (ovld[k] && ordy[k]) begin
          chk("rand_expected", 64'(has[k]), 1);
          chk("rand_prod", prod[k], expv[k]);
          has[k] = 0;
          del_n[k]++;
        end
        if (vld[k] && rdy[k]) begin
          chk("rand_one_in_flight", 64'(has[k]), 0);
          expv[k] = model(a_in[k], b_in[k]);
          has[k] = 1;
          acc_n[k]++;
          fired[k] = 1;
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      chk("drain_empty", 64'(has[k]), 0);
      chk("drain_count", 64'(del_n[k]), 64'(acc_n[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
